// File: rtl/edgetracing_accel_addr_gen.sv
// Raster-scan address generator: drives the external row*stride multiplier and
// adds the column index, delayed to line up with the product, to form each pixel address.
module edgetracing_accel_addr_gen #(
  parameter int ROW_W   = 13,
  parameter int COL_W   = 11,
  parameter int ADDR_W  = 24,
  parameter int MUL_LAT = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  rows,
  input  logic [COL_W-1:0]  cols,
  input  logic [COL_W-1:0]  stride,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  mul_din0,
  output logic [COL_W-1:0]  mul_din1,
  output logic              mul_ce,
  input  logic [ADDR_W-1:0] mul_dout,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   rows_q, row_cnt;
  logic [COL_W-1:0]   cols_q, stride_q, col_cnt;
  logic               ce, issue, col_end, row_end, issue_last;

  logic [COL_W-1:0]   col_p [MUL_LAT];
  logic [MUL_LAT-1:0] vld_p;
  logic [MUL_LAT-1:0] last_p;

  function automatic logic [ADDR_W-1:0] addr_sum(input logic [ADDR_W-1:0] prod,
                                                 input logic [COL_W-1:0]  col);
    return prod + ADDR_W'(col);
  endfunction

  // A stalled output beat freezes everything upstream, including the multiplier.
  assign ce         = ~(out_valid & ~out_ready);
  assign mul_ce     = ce;
  assign mul_din0   = row_cnt;
  assign mul_din1   = stride_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign issue      = (state == SCAN) && ce;
  assign col_end    = (col_cnt == cols_q - 1'b1);
  assign row_end    = (row_cnt == rows_q - 1'b1);
  assign issue_last = col_end && row_end;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (rows == '0 || cols == '0) state_nxt = DONE;
          else                          state_nxt = SCAN;
        end
      end
      SCAN:  if (issue && issue_last) state_nxt = DRAIN;
      DRAIN: if (out_valid && out_ready && out_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rows_q   <= '0;
      cols_q   <= '0;
      stride_q <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
    end else if (ce) begin
      if (state == IDLE && start) begin
        rows_q   <= rows;
        cols_q   <= cols;
        stride_q <= stride;
        row_cnt  <= '0;
        col_cnt  <= '0;
      end else if (issue) begin
        if (col_end) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p0..p(MUL_LAT-1): column/last/valid travel beside the multiplier pipeline.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) col_p[i] <= '0;
      vld_p     <= '0;
      last_p    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_addr  <= '0;
    end else if (ce) begin
      col_p[0] <= col_cnt;
      for (int i = 1; i < MUL_LAT; i++) col_p[i] <= col_p[i-1];
      vld_p     <= {vld_p[MUL_LAT-2:0], issue};
      last_p    <= {last_p[MUL_LAT-2:0], issue && issue_last};
      // Output stage: product meets its delayed column.
      out_valid <= vld_p[MUL_LAT-1];
      out_last  <= last_p[MUL_LAT-1];
      out_addr  <= addr_sum(mul_dout, col_p[MUL_LAT-1]);
    end
  end

endmodule

// File: tb/tb_edgetracing_accel_addr_gen.sv
// Bench for edgetracing_accel_addr_gen: models the 3-stage multiplier and checks the
// address stream against a raster-order reference built from row*stride+col.
module tb_edgetracing_accel_addr_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        start;
  logic [12:0] rows;
  logic [10:0] cols;
  logic [10:0] stride;
  logic        busy, done;
  logic [12:0] mul_din0;
  logic [10:0] mul_din1;
  logic        mul_ce;
  logic [23:0] mul_dout;
  logic [23:0] out_addr;
  logic        out_last, out_valid, out_ready;

  logic [23:0] m1 = '0, m2 = '0, m3 = '0;

  int total = 0;
  int bad   = 0;

  int exp_addr[$];
  bit exp_last[$];
  int got_addr[$];
  bit got_last[$];
  int first_valid_k, last_hs_k, done_k, done_cnt, stall_err, ce_err;
  bit timed_out, busy_at_done, busy_after, any_valid;

  always #5 ap_clk = ~ap_clk;

  edgetracing_accel_addr_gen dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .rows(rows), .cols(cols), .stride(stride),
    .busy(busy), .done(done),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_ce(mul_ce), .mul_dout(mul_dout),
    .out_addr(out_addr), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Multiplier: three clock-enabled register stages, product visible after the third.
  always @(posedge ap_clk) begin
    if (mul_ce === 1'b1) begin
      m1 <= {11'd0, mul_din0} * {13'd0, mul_din1};
      m2 <= m1;
      m3 <= m2;
    end
  end
  assign mul_dout = m3;

  function automatic void build_expected(input int r, input int c, input int s);
    exp_addr.delete();
    exp_last.delete();
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++) begin
        exp_addr.push_back(i * s + j);
        exp_last.push_back(i == r - 1 && j == c - 1);
      end
  endfunction

  task automatic do_start(input int r, input int c, input int s, input bit rdy);
    @(negedge ap_clk);
    rows      = r[12:0];
    cols      = c[10:0];
    stride    = s[10:0];
    start     = 1'b1;
    out_ready = rdy;
  endtask

  // Runs cycles k=1.. after start acceptance and records what the DUT produced.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic collect(input int ready_mode, input int poke_k, input int max_k);
    bit          prev_stall = 1'b0;
    logic [23:0] prev_addr  = '0;
    bit          prev_last  = 1'b0;
    got_addr.delete();
    got_last.delete();
    first_valid_k = -1; last_hs_k = -1; done_k = -1;
    done_cnt = 0; stall_err = 0; ce_err = 0;
    timed_out = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1; any_valid = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge ap_clk);
      start = (k == poke_k);
      if (k == poke_k) begin
        rows = 13'd2; cols = 11'd2; stride = 11'd100;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 4 == 1) || (k % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (out_valid) any_valid = 1'b1;
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (prev_stall && (!out_valid || out_addr !== prev_addr || out_last !== prev_last))
        stall_err++;
      if (mul_ce !== !(out_valid && !out_ready)) ce_err++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          busy_at_done = busy;
        end
      end
      if (out_valid && out_ready) begin
        got_addr.push_back(int'(out_addr));
        got_last.push_back(out_last);
        if (out_last) last_hs_k = k;
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_last  = out_last;
      if (done_k >= 0 && k == done_k + 1) begin
        busy_after = busy;
        return;
      end
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    rows = '0; cols = '0; stride = '0;
    repeat (3) @(negedge ap_clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
    total++; if (out_addr !== 24'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", out_addr); end
    total++; if (mul_din0 !== 13'd0) begin bad++; $display("FAIL reset_din0 got=%0d want=0", mul_din0); end
    total++; if (mul_din1 !== 11'd0) begin bad++; $display("FAIL reset_din1 got=%0d want=0", mul_din1); end
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    build_expected(3, 4, 8);
    do_start(3, 4, 8, 1'b1);
    collect(0, 0, 200);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
    total++; if (got_addr.size() != exp_addr.size())
      begin bad++; $display("FAIL basic_count got=%0d want=%0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL basic_beat%0d got=%0d/%0b want=%0d/%0b", i,
                 (i < got_addr.size()) ? got_addr[i] : -1,
                 (i < got_last.size()) ? got_last[i] : 1'b0, exp_addr[i], exp_last[i]);
      end
    end
    total++; if (first_valid_k != 5)  begin bad++; $display("FAIL basic_first_valid got=%0d want=5", first_valid_k); end
    total++; if (last_hs_k != 16)     begin bad++; $display("FAIL basic_last_hs got=%0d want=16", last_hs_k); end
    total++; if (done_k != 17)        begin bad++; $display("FAIL basic_done_cycle got=%0d want=17", done_k); end
    total++; if (done_cnt != 1)       begin bad++; $display("FAIL basic_done_width got=%0d want=1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy_after); end
  endtask

  task automatic test_backpressure;
    build_expected(3, 4, 8);
    do_start(3, 4, 8, 1'b1);
    collect(1, 0, 400);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
    total++; if (got_addr.size() != exp_addr.size())
      begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL bp_beat%0d got=%0d want=%0d", i,
                 (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
      end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stall_err); end
    total++; if (ce_err != 0)    begin bad++; $display("FAIL bp_mul_ce got=%0d want=0", ce_err); end
    total++; if (done_k != last_hs_k + 1)
      begin bad++; $display("FAIL bp_done_cycle got=%0d want=%0d", done_k, last_hs_k + 1); end
  endtask

  task automatic test_zero_dims;
    int zr[2] = '{0, 2};
    int zc[2] = '{5, 0};
    for (int t = 0; t < 2; t++) begin
      do_start(zr[t], zc[t], 7, 1'b1);
      collect(0, 0, 20);
      total++; if (done_k != 1)   begin bad++; $display("FAIL zero%0d_done_cycle got=%0d want=1", t, done_k); end
      total++; if (any_valid)     begin bad++; $display("FAIL zero%0d_valid got=1 want=0", t); end
      total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL zero%0d_busy got=%b want=1", t, busy_at_done); end
      total++; if (busy_after !== 1'b0)   begin bad++; $display("FAIL zero%0d_busy_after got=%b want=0", t, busy_after); end
    end
  endtask

  task automatic test_max_dims;
    exp_addr.delete();
    exp_last.delete();
    for (int j = 0; j < 4; j++) begin exp_addr.push_back(j); exp_last.push_back(1'b0); end
    for (int j = 2040; j < 2047; j++) begin
      exp_addr.push_back(8190 * 2047 + j);
      exp_last.push_back(j == 2046);
    end
    do_start(8191, 2047, 2047, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge ap_clk);
      start = 1'b0;
      out_ready = 1'b0;
    end
    #1;
    total++; if (out_valid !== 1'b1 || out_addr !== 24'd0)
      begin bad++; $display("FAIL max_stall_head got=%b/%0d want=1/0", out_valid, out_addr); end
    // Jump the frozen scan to the tail of the final row.
    force dut.row_cnt = 13'd8190;
    force dut.col_cnt = 11'd2040;
    @(negedge ap_clk);
    release dut.row_cnt;
    release dut.col_cnt;
    collect(0, 0, 100);
    total++; if (timed_out) begin bad++; $display("FAIL max_timeout got=1 want=0"); end
    total++; if (got_addr.size() != exp_addr.size())
      begin bad++; $display("FAIL max_count got=%0d want=%0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL max_beat%0d got=%0d want=%0d", i,
                 (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    build_expected(3, 4, 8);
    do_start(3, 4, 8, 1'b1);
    collect(0, 3, 200);
    total++; if (got_addr.size() != exp_addr.size())
      begin bad++; $display("FAIL ign_count got=%0d want=%0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL ign_beat%0d got=%0d want=%0d", i,
                 (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
      end
    end
    total++; if (done_k != 17) begin bad++; $display("FAIL ign_done_cycle got=%0d want=17", done_k); end
  endtask

  task automatic test_mid_reset;
    int seen = 0;
    do_start(3, 4, 8, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge ap_clk);
      start = 1'b0;
      out_ready = 1'b1;
    end
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_mid_done got=%b want=0", done); end
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      #1;
      if (out_valid || done) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_leftover got=%0d want=0", seen); end
    build_expected(3, 4, 8);
    do_start(3, 4, 8, 1'b1);
    collect(0, 0, 200);
    total++; if (got_addr.size() != exp_addr.size())
      begin bad++; $display("FAIL rst_rerun_count got=%0d want=%0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL rst_rerun_beat%0d got=%0d want=%0d", i,
                 (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 6; t++) begin
      int r = $urandom_range(1, 4);
      int c = $urandom_range(1, 6);
      int s = $urandom_range(0, 2047);
      build_expected(r, c, s);
      do_start(r, c, s, 1'b1);
      collect(2, 0, 60 * r * c + 50);
      total++; if (timed_out) begin bad++; $display("FAIL rnd%0d_timeout got=1 want=0", t); end
      total++; if (got_addr.size() != exp_addr.size())
        begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", t, got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size(); i++) begin
        total++;
        if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_last[i] !== exp_last[i]) begin
          bad++;
          $display("FAIL rnd%0d_beat%0d got=%0d want=%0d", t, i,
                   (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
        end
      end
      total++; if (stall_err != 0 || ce_err != 0)
        begin bad++; $display("FAIL rnd%0d_stall got=%0d/%0d want=0/0", t, stall_err, ce_err); end
      total++; if (done_k != last_hs_k + 1)
        begin bad++; $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", t, done_k, last_hs_k + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dims();
    test_max_dims();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
